// File: rtl/psram_bus_arbiter.sv
// psram_bus_arbiter
//   Two-master / one-slave arbiter in front of the PSRAM cache. Master 0 is
//   the CPU, master 1 a DMA-style requester such as an LCD framebuffer
//   fetcher. Arbitration is round-robin. A grant is held until the cache
//   returns s_ready, so transactions never interleave. Every completion is
//   followed by at least one idle cycle.
//
//   Optional feature (compile-time macro PSRAM_ARB_TIMEOUT_EN):
//     A granted transaction that waits TIMEOUT_CYCLES busy cycles without
//     s_ready is completed by the arbiter itself. It forces the owner's
//     ready high with read data 32'hDEADBEEF and pulses timeout_err. When
//     the macro is undefined, timeout_err stays 0 and BUSY waits
//     indefinitely.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     mN_ren / mN_wen          master N read request / byte write strobes
//     mN_addr / mN_wdata       master N word address / write data
//     mN_rdata / mN_ready      master N read data / completion pulse
//     s_ren/s_wen/s_addr/s_wdata  forwarded request to the cache
//     s_rdata / s_ready        cache read data / completion
//     busy                     high while a grant is active
//     grant                    one-hot owner (bit0 = m0, bit1 = m1)
//     timeout_err              one-cycle pulse on forced completion
module psram_bus_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_ren,
  input  logic [3:0]            m0_wen,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_ren,
  input  logic [3:0]            m1_wen,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  s_ren,
  output logic [3:0]            s_wen,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  input  logic [31:0]           s_rdata,
  input  logic                  s_ready,
  output logic                  busy,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  // last_q = 1 means master 1 owned the most recent completed transaction.
  logic        last_q,  last_d;

  logic        m0_req, m1_req, owner_req;
  logic        tmo_hit;
  logic        done;
  logic [31:0] rdata_fwd;

  assign m0_req    = m0_ren | (|m0_wen);
  assign m1_req    = m1_ren | (|m1_wen);
  assign owner_req = grant_q[1] ? m1_req : m0_req;

  // A real s_ready always wins over a coincident timeout.
  assign done      = s_ready | tmo_hit;
  assign rdata_fwd = s_ready ? s_rdata : 32'hDEADBEEF;

  assign busy  = (state_q == BUSY);
  assign grant = grant_q;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cleared on entry to BUSY; staying in BUSY implies no s_ready this cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && state_d == BUSY) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo_hit = (state_q == BUSY) && (cnt_q == TMO_LAST);
`else
  // Feature disabled: the timeout never fires.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    s_ren       = 1'b0;
    s_wen       = 4'b0000;
    s_addr      = '0;
    s_wdata     = 32'h0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    timeout_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the master that did not go last wins.
        if (m0_req && (!m1_req || last_q)) begin
          grant_d = 2'b01;
          state_d = BUSY;
        end else if (m1_req) begin
          grant_d = 2'b10;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Only the owner's inputs reach the slave.
        if (grant_q[1]) begin
          s_ren    = m1_ren;
          s_wen    = m1_wen;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          m1_ready = done;
          m1_rdata = rdata_fwd;
        end else begin
          s_ren    = m0_ren;
          s_wen    = m0_wen;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          m0_ready = done;
          m0_rdata = rdata_fwd;
        end

        if (done) begin
          timeout_err = ~s_ready;
          last_d      = grant_q[1];
          grant_d     = 2'b00;
          state_d     = IDLE;
        end else if (!owner_req) begin
          // Owner withdrew early: drop the grant without a ready pulse.
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_psram_bus_arbiter.sv
module tb_psram_bus_arbiter;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_ren, m1_ren;
  logic [3:0]    m0_wen, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;
  logic          s_ren;
  logic [3:0]    s_wen;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [31:0]   s_rdata;
  logic          s_ready;
  logic          busy;
  logic [1:0]    grant;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psram_bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  // Step to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({busy, grant, s_ren, s_wen, m0_ready, m1_ready, timeout_err} !== 11'h0) begin
      bad++;
      $display("FAIL reset_ctrl got=%h exp=0", {busy, grant, s_ren, s_wen, m0_ready, m1_ready, timeout_err});
    end
    total++;
    if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_data addr=%h wdata=%h r0=%h r1=%h exp=0", s_addr, s_wdata, m0_rdata, m1_rdata);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    step();
    m0_ren = 1'b1; m0_addr = 22'h000100;
    @(negedge clk);
    total++;
    if ({busy, s_ren} !== 2'b00) begin
      bad++; $display("FAIL rd_idle got busy/s_ren=%b exp=00", {busy, s_ren});
    end
    step();
    @(negedge clk);
    total++;
    if (grant !== 2'b01 || s_ren !== 1'b1 || s_addr !== 22'h000100) begin
      bad++; $display("FAIL rd_fwd grant=%b s_ren=%b addr=%h exp 01/1/000100", grant, s_ren, s_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      total++;
      if (m0_ready !== 1'b0 || s_ren !== 1'b1) begin
        bad++; $display("FAIL rd_wait%0d m0_ready=%b s_ren=%b exp 0/1", i, m0_ready, s_ren);
      end
    end
    step();
    s_ready = 1'b1; s_rdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678 || m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin
      bad++; $display("FAIL rd_done m0 %b/%h m1 %b/%h exp 1/12345678 0/0", m0_ready, m0_rdata, m1_ready, m1_rdata);
    end
    step();
    s_ready = 1'b0; m0_ren = 1'b0;
    @(negedge clk);
    total++;
    if ({grant, busy, s_ren, m0_ready} !== 5'b0) begin
      bad++; $display("FAIL rd_after got=%b exp=00000", {grant, busy, s_ren, m0_ready});
    end
  endtask

  task automatic test_tie();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_ren = 1'b1; m0_addr = 22'h000010;
    m1_ren = 1'b1; m1_addr = 22'h000020;
    @(negedge clk);
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL tie_idle grant=%b exp=00", grant);
    end
    step();
    @(negedge clk);
    total++;
    if (grant !== 2'b01 || s_addr !== 22'h000010) begin
      bad++; $display("FAIL tie_first grant=%b addr=%h exp 01/000010", grant, s_addr);
    end
    step();
    s_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({m0_ready, m1_ready} !== 2'b10) begin
      bad++; $display("FAIL tie_rdy0 got=%b exp=10", {m0_ready, m1_ready});
    end
    step();
    s_ready = 1'b0; m0_ren = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 2'b00 || s_ren !== 1'b0) begin
      bad++; $display("FAIL tie_gap grant=%b s_ren=%b exp 00/0", grant, s_ren);
    end
    step();
    @(negedge clk);
    total++;
    if (grant !== 2'b10 || s_addr !== 22'h000020) begin
      bad++; $display("FAIL tie_second grant=%b addr=%h exp 10/000020", grant, s_addr);
    end
    step();
    s_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      bad++; $display("FAIL tie_rdy1 got=%b exp=01", {m0_ready, m1_ready});
    end
    step();
    s_ready = 1'b0; m1_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    step();
    m0_ren = 1'b1; m0_addr = 22'h0000A0;
    m1_ren = 1'b1; m1_addr = 22'h0000B0;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      @(negedge clk);
      total++;
      if (grant !== exp_g || s_ren !== 1'b1) begin
        bad++; $display("FAIL b2b_grant%0d grant=%b s_ren=%b exp %b/1", i, grant, s_ren, exp_g);
      end
      step();
      s_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({m1_ready, m0_ready} !== exp_g) begin
        bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, {m1_ready, m0_ready}, exp_g);
      end
      step();
      s_ready = 1'b0;
      if (i == 5) begin
        m0_ren = 1'b0; m1_ren = 1'b0;
      end
      @(negedge clk);
      total++;
      if (grant !== 2'b00 || s_ren !== 1'b0) begin
        bad++; $display("FAIL b2b_gap%0d grant=%b s_ren=%b exp 00/0", i, grant, s_ren);
      end
    end
  endtask

  task automatic test_write_stable();
    step();
    m1_wen = 4'b0011; m1_addr = 22'h3FFFFF; m1_wdata = 32'hAABBCCDD;
    step();
    for (int i = 0; i < 4; i++) begin
      m0_ren   = i[0];
      m0_wen   = i[1] ? 4'b1100 : 4'b0000;
      m0_addr  = 22'(i * 22'h012345);
      m0_wdata = 32'h11111111 * i;
      @(negedge clk);
      total++;
      if (s_wen !== 4'b0011 || s_addr !== 22'h3FFFFF || s_wdata !== 32'hAABBCCDD ||
          s_ren !== 1'b0 || grant !== 2'b10 || m0_ready !== 1'b0 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL wr_stable%0d wen=%b addr=%h wdata=%h ren=%b grant=%b m0_ready=%b terr=%b exp 0011/3fffff/aabbccdd/0/10/0/0",
                        i, s_wen, s_addr, s_wdata, s_ren, grant, m0_ready, timeout_err);
      end
      step();
    end
    s_ready = 1'b1; s_rdata = 32'h55AA55AA;
    m0_ren = 1'b0; m0_wen = 4'b0000;
    @(negedge clk);
    total++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h55AA55AA || m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      bad++; $display("FAIL wr_done m1 %b/%h m0 %b/%h exp 1/55aa55aa 0/0", m1_ready, m1_rdata, m0_ready, m0_rdata);
    end
    step();
    s_ready = 1'b0; m1_wen = 4'b0000;
    @(negedge clk);
    total++;
    if (grant !== 2'b00 || s_wen !== 4'b0000) begin
      bad++; $display("FAIL wr_after grant=%b s_wen=%b exp 00/0000", grant, s_wen);
    end
  endtask

  task automatic test_abort();
    step();
    m0_ren = 1'b1; m0_addr = 22'h000044;
    step();
    @(negedge clk);
    total++;
    if (grant !== 2'b01) begin
      bad++; $display("FAIL abort_grant grant=%b exp=01", grant);
    end
    step();
    m0_ren = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || m0_ready !== 1'b0) begin
      bad++; $display("FAIL abort_drop busy=%b m0_ready=%b exp 1/0", busy, m0_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b grant=%b m0_ready=%b exp 0/00/0", busy, grant, m0_ready);
    end
  endtask

  task automatic test_async_reset();
    // Complete an m0 transaction so the round-robin pointer favours m1.
    step();
    m0_ren = 1'b1; m0_addr = 22'h000001;
    step();
    s_ready = 1'b1;
    step();
    s_ready = 1'b0; m0_ren = 1'b0;
    m1_ren = 1'b1; m1_wen = 4'b1111; m1_addr = 22'h000077;
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant !== 2'b10 || s_ren !== 1'b1 || s_wen !== 4'b1111) begin
      bad++; $display("FAIL arst_pre busy=%b grant=%b ren=%b wen=%b exp 1/10/1/1111", busy, grant, s_ren, s_wen);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, grant, s_ren, s_wen} !== 8'h0) begin
      bad++; $display("FAIL arst_drop got=%b exp=0", {busy, grant, s_ren, s_wen});
    end
    m0_ren = 1'b1; m0_addr = 22'h000002;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL arst_idle grant=%b exp=00", grant);
    end
    step();
    @(negedge clk);
    total++;
    if (grant !== 2'b01 || s_addr !== 22'h000002) begin
      bad++; $display("FAIL arst_tie grant=%b addr=%h exp 01/000002", grant, s_addr);
    end
    step();
    s_ready = 1'b1;
    step();
    s_ready = 1'b0; m0_ren = 1'b0; m1_ren = 1'b0; m1_wen = 4'b0000;
    step();
    step();
    @(negedge clk);
  endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    step();
    m0_ren = 1'b1; m0_addr = 22'h000123;
    step();
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      total++;
      if (m0_ready !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL tmo_wait%0d ready=%b terr=%b busy=%b exp 0/0/1", k, m0_ready, timeout_err, busy);
      end
      step();
    end
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF || timeout_err !== 1'b1) begin
      bad++; $display("FAIL tmo_fire ready=%b rdata=%h terr=%b exp 1/deadbeef/1", m0_ready, m0_rdata, timeout_err);
    end
    step();
    m0_ren = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || m0_ready !== 1'b0) begin
      bad++; $display("FAIL tmo_after busy=%b terr=%b ready=%b exp 0/0/0", busy, timeout_err, m0_ready);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog sim time expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_ren = 1'b0; m0_wen = 4'b0; m0_addr = '0; m0_wdata = '0;
    m1_ren = 1'b0; m1_wen = 4'b0; m1_addr = '0; m1_wdata = '0;
    s_rdata = 32'h0; s_ready = 1'b0;
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_write_stable();
    test_abort();
    test_async_reset();
`ifdef PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
